// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the EX-stage hazard and forwarding unit: the forwarding
// mux select codes, the hazard FSM states and the per-stage shadow record
// that the unit keeps for the instructions in EX and MEM.
package hazard_forward_unit_pkg;

  localparam int GPR_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } haz_state_t;

  typedef struct packed {
    logic              valid;
    logic [GPR_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '0;

  // A stage is a forwarding source only if it holds a real instruction that
  // writes a register other than the hardwired-zero x0.
  function automatic logic writes_reg(input stage_info_t s);
    return s.valid & s.reg_write & (s.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_compare.sv
// Operand forwarding compare: picks the nearest in-flight producer of one
// source register. The instruction currently in EX will sit in MEM when the
// consumer reaches EX, and the one in MEM will sit in WB.
module fwd_compare
  import hazard_forward_unit_pkg::*;
(
  input  logic [GPR_AW-1:0] rs,
  input  stage_info_t       ex,
  input  stage_info_t       mem,
  output fwd_sel_t          sel
);

  // Nearest producer first; x0 never forwards because writes_reg excludes rd=0.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (writes_reg(ex) && (rs == ex.rd)) begin
      sel = FWD_MEM;
    end else if (writes_reg(mem) && (rs == mem.rd)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage core. Tracks the
// destination registers of the EX and MEM instructions in a shadow pipe fed
// from decode, registers the ALU operand mux selects, and decodes stall,
// bubble, flush and freeze controls. A WB copy of the shadow is not kept:
// a producer that has left MEM is served by the register file, so nothing
// would ever read it.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW = GPR_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              dmem_ready,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              freeze
);

  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t id_info;
  fwd_sel_t    fwd_a_q;
  fwd_sel_t    fwd_b_q;
  fwd_sel_t    sel_a_next;
  fwd_sel_t    sel_b_next;
  haz_state_t  state_q;
  haz_state_t  state_next;
  logic        mem_wait;
  logic        load_use;

  assign id_info = '{valid:     id_valid,
                     rd:        id_rd,
                     reg_write: id_reg_write,
                     mem_read:  id_mem_read};

  fwd_compare u_fwd_a (
    .rs  (id_rs1),
    .ex  (ex_q),
    .mem (mem_q),
    .sel (sel_a_next)
  );

  fwd_compare u_fwd_b (
    .rs  (id_rs2),
    .ex  (ex_q),
    .mem (mem_q),
    .sel (sel_b_next)
  );

  // A load sitting in MEM that memory has not yet completed.
  assign mem_wait = mem_q.valid & mem_q.mem_read & ~dmem_ready;

  // The decode instruction needs a value that the load in EX has not fetched yet.
  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));

  // Decode controls from state and inputs; freeze beats branch beats load-use.
  always_comb begin
    freeze      = 1'b0;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    state_next  = RUN;

    case (state_q)
      MEM_WAIT: freeze = ~dmem_ready;
      default:  freeze = mem_wait;
    endcase

    if (freeze) begin
      state_next = MEM_WAIT;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_next  = LU_STALL;
    end
  end

  // Advance the shadow pipe and registered selects unless memory holds the core.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!freeze) begin
      mem_q   <= ex_q;
      ex_q    <= flush_id_ex ? BUBBLE : id_info;
      fwd_a_q <= flush_id_ex ? FWD_RF : sel_a_next;
      fwd_b_q <= flush_id_ex ? FWD_RF : sel_b_next;
    end
  end

  // Hazard FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_next;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule
